// File: rtl/branch_history_table_if.sv
// Fetch/execute-side signal bundle for the branch history table.
// The pipeline is the master; the table itself is the slave.
interface branch_history_table_if;
    logic        IF_valid;
    logic [31:0] IF_pc;
    logic [1:0]  IF_branch_prediction;
    logic        IF_predict_taken;
    logic        IF_pred_valid;
    logic        EX_update_valid;
    logic [31:0] EX_pc;
    logic [1:0]  EX_branch_prediction;
    logic        EX_branch_taken;
    logic        ready;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output IF_valid, IF_pc,
        output EX_update_valid, EX_pc, EX_branch_prediction, EX_branch_taken,
        input  IF_branch_prediction, IF_predict_taken, IF_pred_valid,
        input  ready, branch_count, mispredict_count
    );

    modport slave (
        input  IF_valid, IF_pc,
        input  EX_update_valid, EX_pc, EX_branch_prediction, EX_branch_taken,
        output IF_branch_prediction, IF_predict_taken, IF_pred_valid,
        output ready, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_history_table.sv
// Per-PC table of 2-bit saturating counters: 1-cycle lookup for fetch, same-edge training
// from EX with a write-first bypass, plus saturating branch / misprediction statistics.
module branch_history_table #(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input logic                   clk,
    input logic                   rst_n,
    branch_history_table_if.slave bus
);
    localparam int ENTRIES = 2 ** INDEX_BITS;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  state_q, state_d;
    logic [INDEX_BITS-1:0]   sweep_q, sweep_d;
    logic [1:0]              table_q [ENTRIES];
    logic [1:0]              pred_q;
    logic                    pred_valid_q;
    logic [31:0]             branch_q, mispredict_q;

    logic [INDEX_BITS-1:0]   if_idx, ex_idx;
    logic                    run, upd_en, lookup_en, mispredict;
    logic [1:0]              upd_val;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v == 2'b00) ? v : v - 2'd1;
    endfunction

    assign if_idx     = bus.IF_pc[INDEX_BITS+1:2];
    assign ex_idx     = bus.EX_pc[INDEX_BITS+1:2];
    assign run        = (state_q == S_RUN);
    assign upd_en     = run && bus.EX_update_valid;
    assign lookup_en  = run && bus.IF_valid;
    assign upd_val    = bus.EX_branch_taken ? sat_inc(bus.EX_branch_prediction)
                                            : sat_dec(bus.EX_branch_prediction);
    assign mispredict = bus.EX_branch_prediction[1] != bus.EX_branch_taken;

    // Only the index bits of each PC address the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.IF_pc[31:INDEX_BITS+2], bus.IF_pc[1:0],
                              bus.EX_pc[31:INDEX_BITS+2], bus.EX_pc[1:0]};

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            S_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (&sweep_q) state_d = S_RUN;
            end
            S_RUN:   ;
            default: state_d = S_INIT;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            sweep_q      <= '0;
            pred_q       <= 2'b00;
            pred_valid_q <= 1'b0;
            branch_q     <= '0;
            mispredict_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            pred_valid_q <= lookup_en;
            if (lookup_en)
                pred_q <= (upd_en && ex_idx == if_idx) ? upd_val : table_q[if_idx];
            if (upd_en) begin
                if (branch_q != '1) branch_q <= branch_q + 32'd1;
                if (mispredict && mispredict_q != '1) mispredict_q <= mispredict_q + 32'd1;
            end
        end
    end

    // NOTE: the table has no reset branch; the INIT sweep fills it, keeping it a plain RAM.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == S_INIT) table_q[sweep_q] <= INIT_STATE;
            else if (upd_en)       table_q[ex_idx]  <= upd_val;
        end
    end

    assign bus.ready                = run;
    assign bus.IF_branch_prediction = pred_q;
    assign bus.IF_predict_taken     = pred_q[1];
    assign bus.IF_pred_valid        = pred_valid_q;
    assign bus.branch_count         = branch_q;
    assign bus.mispredict_count     = mispredict_q;
endmodule
